fpadd_scheduler: RTL and testbench

FPADD_SCHEDULER -- requirements
Module: fpadd_scheduler

---
 rtl/fpadd_scheduler.sv | 244 ++++++++++++++++++++++++
 tb/tb_fpadd_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_scheduler.sv
// -----------------------------------------------------------------------------
// fpadd_scheduler
//
// Shares one fixed-latency floating-point adder datapath between two
// requesters. Each requester hands over one operand pair at a time. The block
// arbitrates, issues the pair to the adder, tracks the operation through a
// LATENCY-deep tag pipeline, and holds the returned sum on that requester's
// response port until it is accepted. Sums pass through untouched; this block
// does not interpret the IEEE-754 encoding.
//
// Configuration macro:
//   FPADD_SCHED_FIXED_PRIO_EN  defined   -> requester 0 always wins a tie and
//                                           there is no round-robin pointer
//                              undefined -> round-robin arbitration (default)
//
// Parameters:
//   LATENCY    cycles from dp_issue to the matching dp_result (legal 1..8)
//
// Ports:
//   clk                 single clock, rising edge
//   reset_n             asynchronous active-low reset
//   req_valid[1:0]      per-requester operand pair valid
//   req_a0/req_b0       requester 0 operands
//   req_a1/req_b1       requester 1 operands
//   req_ready[1:0]      combinational accept, high only for the granted requester
//   dp_a/dp_b           registered operands to the shared adder
//   dp_issue            one-cycle strobe qualifying dp_a/dp_b
//   dp_result           adder sum, valid LATENCY cycles after dp_issue
//   rsp_data0/1         per-requester held result
//   rsp_valid[1:0]      per-requester result valid
//   rsp_ready[1:0]      per-requester result accept
//   busy                high while any requester has an operation outstanding
// -----------------------------------------------------------------------------
module fpadd_scheduler #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic [1:0]  req_ready,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  output logic        dp_issue,
  input  logic [31:0] dp_result,
  output logic [31:0] rsp_data0,
  output logic [31:0] rsp_data1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    DONE     = 2'd2
  } req_state_e;

  // One entry per datapath pipeline stage: is an op there, and whose is it.
  typedef struct packed {
    logic valid;
    logic tag;
  } slot_t;

  req_state_e            state_q [2];
  req_state_e            state_d [2];
  logic [1:0]            eligible;
  logic [1:0]            grant;
  logic                  issue_tag;
  slot_t [LATENCY-1:0]   sr_q;
  slot_t                 ret;

  // Entry leaving the tag pipeline lines up with the adder's sum this cycle.
  assign ret = sr_q[LATENCY-1];

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // A requester can only be granted from IDLE, so a response accepted this
  // cycle frees it for a new grant no earlier than the next cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      eligible[i] = (state_q[i] == IDLE) && req_valid[i];
    end
  end

`ifdef FPADD_SCHED_FIXED_PRIO_EN
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path can leave it unassigned and infer a latch.
    grant = 2'b00;
    if (eligible[0]) begin
      grant = 2'b01;
    end else if (eligible[1]) begin
      grant = 2'b10;
    end
    // Nothing may be accepted while reset is held.
    if (!reset_n) begin
      grant = 2'b00;
    end
  end
`else
  // rr_ptr names the requester that wins the next tie; it starts at 0 and
  // points away from whoever was granted last.
  logic rr_ptr;

  always_comb begin
    grant = 2'b00;
    if (eligible == 2'b11) begin
      grant = rr_ptr ? 2'b10 : 2'b01;
    end else begin
      grant = eligible;
    end
    if (!reset_n) begin
      grant = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= 1'b0;
    end else if (grant != 2'b00) begin
      // Granting 0 favours 1 next time, granting 1 favours 0.
      rr_ptr <= grant[0];
    end
  end
`endif

  assign req_ready = grant;

  // ---------------------------------------------------------------------------
  // Per-requester FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
      end
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-requester FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (grant[i]) begin
            state_d[i] = INFLIGHT;
          end
        end
        INFLIGHT: begin
          if (ret.valid && (ret.tag == 1'(i))) begin
            state_d[i] = DONE;
          end
        end
        DONE: begin
          if (rsp_ready[i]) begin
            state_d[i] = IDLE;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-requester FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_valid = 2'b00;
    busy      = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rsp_valid[i] = (state_q[i] == DONE);
      busy         = busy | (state_q[i] != IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Issue register: the granted pair goes to the adder on the next cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_a      <= '0;
      dp_b      <= '0;
      dp_issue  <= 1'b0;
      issue_tag <= 1'b0;
    end else begin
      dp_issue <= (grant != 2'b00);
      if (grant != 2'b00) begin
        dp_a      <= grant[1] ? req_a1 : req_a0;
        dp_b      <= grant[1] ? req_b1 : req_b0;
        issue_tag <= grant[1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline mirroring the adder. Clearing it on reset is what drops
  // in-flight work: sums still emerging from the adder afterwards meet an
  // invalid entry and are ignored.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else begin
      sr_q[0].valid <= dp_issue;
      sr_q[0].tag   <= issue_tag;
      for (int k = 1; k < LATENCY; k++) begin
        sr_q[k] <= sr_q[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result capture. Only a valid pipeline exit writes, and a requester has at
  // most one op outstanding, so a DONE requester's data cannot change until it
  // has been accepted and re-issued.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data0 <= '0;
      rsp_data1 <= '0;
    end else if (ret.valid) begin
      if (ret.tag) begin
        rsp_data1 <= dp_result;
      end else begin
        rsp_data0 <= dp_result;
      end
    end
  end

endmodule

// File: tb/tb_fpadd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fpadd_scheduler
//
// Two scheduler instances: LATENCY=3 (main) and LATENCY=1. Each has a bench
// adder model that looks the issued pair up in a table of hand-computed
// IEEE-754 sums and presents it LATENCY cycles after dp_issue, and garbage
// otherwise. A driver turns per-requester vector queues into handshakes and
// pushes the expected sum on each accept; a monitor pops and compares on each
// response handshake.
// -----------------------------------------------------------------------------
module tb_fpadd_scheduler;

  localparam int LAT = 3;
  localparam int NV  = 8;

  // a + b = s, hand-computed single-precision encodings
  localparam logic [31:0] VEC_A [NV] = '{
    32'h3F800000, 32'h3FC00000, 32'h3F000000, 32'h40400000,
    32'hBF800000, 32'h41200000, 32'h40000000, 32'h42C80000};
  localparam logic [31:0] VEC_B [NV] = '{
    32'h40000000, 32'h40200000, 32'h3E800000, 32'h40800000,
    32'h3F800000, 32'h40C00000, 32'h40000000, 32'h41E00000};
  localparam logic [31:0] VEC_S [NV] = '{
    32'h40400000, 32'h40800000, 32'h3F400000, 32'h40E00000,
    32'h00000000, 32'h41800000, 32'h40800000, 32'h43000000};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [31:0] dp_a, dp_b, dp_result, rsp_data0, rsp_data1;
  logic        dp_issue, busy;

  logic [1:0]  req_valid_l1, req_ready_l1, rsp_valid_l1, rsp_ready_l1;
  logic [31:0] req_a0_l1, req_b0_l1, req_a1_l1, req_b1_l1;
  logic [31:0] dp_a_l1, dp_b_l1, dp_result_l1, rsp_data0_l1, rsp_data1_l1;
  logic        dp_issue_l1, busy_l1;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always #5 clk = ~clk;

  fpadd_scheduler #(.LATENCY(LAT)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_ready(req_ready), .dp_a(dp_a), .dp_b(dp_b), .dp_issue(dp_issue),
    .dp_result(dp_result), .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .busy(busy));

  fpadd_scheduler #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid_l1),
    .req_a0(req_a0_l1), .req_b0(req_b0_l1), .req_a1(req_a1_l1), .req_b1(req_b1_l1),
    .req_ready(req_ready_l1), .dp_a(dp_a_l1), .dp_b(dp_b_l1), .dp_issue(dp_issue_l1),
    .dp_result(dp_result_l1), .rsp_data0(rsp_data0_l1), .rsp_data1(rsp_data1_l1),
    .rsp_valid(rsp_valid_l1), .rsp_ready(rsp_ready_l1), .busy(busy_l1));

  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < NV; k++) begin
      if (a == VEC_A[k] && b == VEC_B[k]) return VEC_S[k];
    end
    return 32'hDEADBEEF;
  endfunction

  // Adder models: sum appears LATENCY cycles after the dp_issue cycle.
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= dp_issue ? fp_model(dp_a, dp_b) : 32'hDEADBEEF;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign dp_result = pipe[LAT-1];

  always @(posedge clk) begin
    dp_result_l1 <= dp_issue_l1 ? fp_model(dp_a_l1, dp_b_l1) : 32'hDEADBEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard state
  typedef struct {
    int req;
    int cyc;
  } grant_t;

  int          vq0 [$];
  int          vq1 [$];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  grant_t      glog [$];

  // Driver: present queue heads, record accepts and the expected sums.
  initial begin
    grant_t g;
    req_valid = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    forever begin
      @(posedge clk); #1;
      req_valid[0] = (vq0.size() != 0);
      req_valid[1] = (vq1.size() != 0);
      if (vq0.size() != 0) begin req_a0 = VEC_A[vq0[0]]; req_b0 = VEC_B[vq0[0]]; end
      if (vq1.size() != 0) begin req_a1 = VEC_A[vq1[0]]; req_b1 = VEC_B[vq1[0]]; end
      @(negedge clk);
      cycle++;
      if (req_valid[0] && req_ready[0]) begin
        exp_q0.push_back(VEC_S[vq0[0]]);
        void'(vq0.pop_front());
        g.req = 0; g.cyc = cycle; glog.push_back(g);
      end
      if (req_valid[1] && req_ready[1]) begin
        exp_q1.push_back(VEC_S[vq1[0]]);
        void'(vq1.pop_front());
        g.req = 1; g.cyc = cycle; glog.push_back(g);
      end
    end
  end

  // Monitor: compare on every response handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (rsp_valid[0] && rsp_ready[0]) begin
          if (exp_q0.size() == 0) check("rsp0_unexpected", {31'b0, rsp_valid[0]}, 32'd0);
          else                    check("rsp0_data", rsp_data0, exp_q0.pop_front());
        end
        if (rsp_valid[1] && rsp_ready[1]) begin
          if (exp_q1.size() == 0) check("rsp1_unexpected", {31'b0, rsp_valid[1]}, 32'd0);
          else                    check("rsp1_data", rsp_data1, exp_q1.pop_front());
        end
      end
    end
  end

  // Main-process sampling point: after driver and monitor at the falling edge.
  task automatic tick();
    @(negedge clk); #2;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((vq0.size() != 0 || vq1.size() != 0 || exp_q0.size() != 0 ||
            exp_q1.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drain"}, {31'b0, n < budget}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_ready"}, {30'b0, req_ready}, 32'd0);
    check({name, "_dp_issue"},  {31'b0, dp_issue},  32'd0);
    check({name, "_dp_a"},      dp_a,               32'd0);
    check({name, "_dp_b"},      dp_b,               32'd0);
    check({name, "_rsp_data0"}, rsp_data0,          32'd0);
    check({name, "_rsp_data1"}, rsp_data1,          32'd0);
    check({name, "_rsp_valid"}, {30'b0, rsp_valid}, 32'd0);
    check({name, "_busy"},      {31'b0, busy},      32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat, served, w0, w1;
    logic [31:0] held;
    int exp_seq [6];
    int g_cyc [2];
    int r_cyc [2];
    logic [31:0] r_data [2];
    logic [1:0] done_mask;

    reset_n = 1'b0;
    rsp_ready = 2'b11;
    req_valid_l1 = 2'b00; rsp_ready_l1 = 2'b11;
    req_a0_l1 = '0; req_b0_l1 = '0; req_a1_l1 = '0; req_b1_l1 = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();

    // T1: single op on requester 0, 1.0 + 2.0
    glog.delete();
    vq0.push_back(0);
    n = 0;
    while (glog.size() == 0 && n < 20) begin tick(); n++; end
    check("t1_grant_req", (glog.size() != 0) ? glog[0].req : -1, 0);
    tick();
    check("t1_dp_issue", {31'b0, dp_issue}, 32'd1);
    check("t1_dp_a", dp_a, 32'h3F800000);
    check("t1_dp_b", dp_b, 32'h40000000);
    lat = 1;
    while (!rsp_valid[0] && lat < 20) begin
      tick();
      lat++;
      if (lat == 2) check("t1_issue_strobe", {31'b0, dp_issue}, 32'd0);
    end
    check("t1_rsp_latency", lat, LAT + 2);
    check("t1_rsp_valid", {30'b0, rsp_valid}, 32'd1);
    check("t1_rsp_data0", rsp_data0, 32'h40400000);
    wait_idle("t1", 50);

    // T2: both requesters streaming; after T1 the tie goes to requester 1
`ifdef FPADD_SCHED_FIXED_PRIO_EN
    exp_seq = '{0, 1, 0, 1, 0, 1};
`else
    exp_seq = '{1, 0, 1, 0, 1, 0};
`endif
    glog.delete();
    vq0 = '{1, 2, 3};
    vq1 = '{4, 5, 6};
    wait_idle("t2", 200);
    check("t2_grant_count", glog.size(), 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t2_grant%0d", k), (glog.size() > k) ? glog[k].req : -1, exp_seq[k]);
    end
    if (glog.size() >= 2) check("t2_back_to_back", glog[1].cyc - glog[0].cyc, 1);

    // T3: requester 0 stalls its response; requester 1 keeps being served
    @(posedge clk); #1;
    rsp_ready = 2'b10;
    glog.delete();
    vq0 = '{7, 0};
    vq1 = '{1, 2, 3, 5};
    n = 0;
    while (!rsp_valid[0] && n < 30) begin tick(); n++; end
    held = rsp_data0;
    check("t3_first_data", held, VEC_S[7]);
    w0 = 0;
    foreach (glog[k]) if (glog[k].req == 1) w0++;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t3_hold_valid", {31'b0, rsp_valid[0]}, 32'd1);
      check("t3_hold_data", rsp_data0, held);
      check("t3_no_grant0", {31'b0, req_ready[0]}, 32'd0);
    end
    w1 = 0;
    foreach (glog[k]) if (glog[k].req == 1) w1++;
    served = w1 - w0;
    check("t3_req1_served", {31'b0, served > 0}, 32'd1);
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    wait_idle("t3", 200);

    // T4: reset while two ops are in flight
    glog.delete();
    vq0.push_back(4);
    vq1.push_back(5);
    n = 0;
    while (glog.size() < 2 && n < 20) begin tick(); n++; end
    check("t4_both_granted", glog.size(), 2);
    tick();
    @(posedge clk); #2;
    reset_n = 1'b0;
    vq0.delete(); vq1.delete(); exp_q0.delete(); exp_q1.delete();
    tick();
    check_reset_outputs("t4");
    tick();
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < LAT + 6; k++) begin
      tick();
      check("t4_no_rsp_valid", {30'b0, rsp_valid}, 32'd0);
      check("t4_not_busy", {31'b0, busy}, 32'd0);
    end

    // T5: LATENCY=1 instance, back-to-back issues to 0 then 1
    g_cyc = '{-1, -1};
    r_cyc = '{-1, -1};
    r_data = '{32'd0, 32'd0};
    done_mask = 2'b00;
    req_a0_l1 = VEC_A[2]; req_b0_l1 = VEC_B[2];
    req_a1_l1 = VEC_A[5]; req_b1_l1 = VEC_B[5];
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      req_valid_l1 = ~done_mask;
      @(negedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (req_valid_l1[i] && req_ready_l1[i]) begin
          done_mask[i] = 1'b1;
          g_cyc[i] = t;
        end
        if (rsp_valid_l1[i] && r_cyc[i] < 0) begin
          r_cyc[i] = t;
          r_data[i] = (i == 1) ? rsp_data1_l1 : rsp_data0_l1;
        end
      end
    end
    req_valid_l1 = 2'b00;
    check("t5_grant0_cycle", g_cyc[0], 0);
    check("t5_grant1_cycle", g_cyc[1], 1);
    check("t5_rsp0_cycle", r_cyc[0], 3);
    check("t5_rsp1_cycle", r_cyc[1], 4);
    check("t5_rsp0_data", r_data[0], VEC_S[2]);
    check("t5_rsp1_data", r_data[1], VEC_S[5]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
